// File: rtl/bpf_tone_detector.sv
`default_nettype none
// ============================================================================
// Module   : bpf_tone_detector
// Purpose  : Post-FIR tone detector. Saturates the band-pass FIR output to a
//            signed OUT_WIDTH sample, sums sample magnitudes over windows of
//            2^WIN_LOG2 accepted samples, and drives a hysteresis FSM that
//            raises a debounced tone-present flag.
// Ports    : clk, rst (async, active-high)
//            in_valid, y_in        : FIR sample input
//            clear                 : sync clear of window/accumulator/FSM
//            th_on, th_off         : energy thresholds (enter / leave detect)
//            sat_out, sat_valid,
//            sat_flag              : saturated sample stream
//            energy, energy_valid  : per-window magnitude sum
//            detect, det_rise,
//            det_fall              : debounced detect level and edge pulses
// Revision : 1.0 - initial release
// ============================================================================
module bpf_tone_detector #(
    parameter int IN_WIDTH  = 39,
    parameter int OUT_WIDTH = 16,
    parameter int WIN_LOG2  = 8,
    parameter int CONFIRM   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [IN_WIDTH-1:0]             y_in,
    input  logic                            clear,
    input  logic [OUT_WIDTH-2+WIN_LOG2:0]   th_on,
    input  logic [OUT_WIDTH-2+WIN_LOG2:0]   th_off,
    output logic [OUT_WIDTH-1:0]            sat_out,
    output logic                            sat_valid,
    output logic                            sat_flag,
    output logic [OUT_WIDTH-2+WIN_LOG2:0]   energy,
    output logic                            energy_valid,
    output logic                            detect,
    output logic                            det_rise,
    output logic                            det_fall
);

    localparam int c_acc_w = OUT_WIDTH - 1 + WIN_LOG2;

    // Symmetric clip limits: -2^(OUT_WIDTH-1) is clipped too so |x| fits in
    // OUT_WIDTH-1 bits.
    localparam logic signed [IN_WIDTH-1:0] c_sat_max =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] c_sat_min = -c_sat_max;

    localparam logic [OUT_WIDTH-2:0] c_mag_one = {{(OUT_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [WIN_LOG2-1:0]  c_win_one = {{(WIN_LOG2-1){1'b0}}, 1'b1};
    localparam logic [3:0]           c_cnt_one = 4'd1;
    localparam logic [3:0]           c_confirm = 4'(CONFIRM);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMING    = 2'd1,
        S_ACTIVE    = 2'd2,
        S_RELEASING = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] r_sat_q,       w_sat_d;
    logic                 r_sat_flag_q,  w_sat_flag_d;
    logic                 r_sat_valid_q;
    logic [c_acc_w-1:0]   r_acc_q,       w_acc_d;
    logic [WIN_LOG2-1:0]  r_win_q,       w_win_d;
    logic [c_acc_w-1:0]   r_energy_q,    w_energy_d;
    logic                 r_energy_valid_q, w_energy_valid_d;
    state_t               r_state_q,     w_state_d;
    logic [3:0]           r_cnt_q,       w_cnt_d;
    logic                 r_detect_q,    w_detect_d;
    logic                 r_rise_q,      w_rise_d;
    logic                 r_fall_q,      w_fall_d;

    logic [OUT_WIDTH-2:0] w_mag;
    logic [c_acc_w-1:0]   w_mag_ext;
    logic                 w_hi;
    logic                 w_lo;

    // ------------------------------------------------------------------
    // Stage 1: saturation (independent of clear)
    // ------------------------------------------------------------------
    always_comb begin
        w_sat_d      = r_sat_q;
        w_sat_flag_d = r_sat_flag_q;
        if (in_valid) begin
            if ($signed(y_in) > c_sat_max) begin
                w_sat_d      = c_sat_max[OUT_WIDTH-1:0];
                w_sat_flag_d = 1'b1;
            end else if ($signed(y_in) < c_sat_min) begin
                w_sat_d      = c_sat_min[OUT_WIDTH-1:0];
                w_sat_flag_d = 1'b1;
            end else begin
                w_sat_d      = y_in[OUT_WIDTH-1:0];
                w_sat_flag_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude accumulation over the window
    // ------------------------------------------------------------------
    // The most negative code never reaches here, so two's-complement negate
    // on the low bits yields the exact magnitude.
    assign w_mag     = r_sat_q[OUT_WIDTH-1] ? (~r_sat_q[OUT_WIDTH-2:0] + c_mag_one)
                                            : r_sat_q[OUT_WIDTH-2:0];
    assign w_mag_ext = {{WIN_LOG2{1'b0}}, w_mag};

    always_comb begin
        w_acc_d          = r_acc_q;
        w_win_d          = r_win_q;
        w_energy_d       = r_energy_q;
        w_energy_valid_d = 1'b0;
        if (clear) begin
            // Clear wins: a coinciding sample is dropped from the window.
            w_acc_d = '0;
            w_win_d = '0;
        end else if (r_sat_valid_q) begin
            w_win_d = r_win_q + c_win_one;
            if (&r_win_q) begin
                w_energy_d       = r_acc_q + w_mag_ext;
                w_energy_valid_d = 1'b1;
                w_acc_d          = '0;
            end else begin
                w_acc_d = r_acc_q + w_mag_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hysteresis FSM, evaluated once per completed window
    // ------------------------------------------------------------------
    assign w_hi = (r_energy_q >= th_on);
    assign w_lo = (r_energy_q <  th_off);

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_detect_d = r_detect_q;
        w_rise_d   = 1'b0;
        w_fall_d   = 1'b0;
        if (clear) begin
            // Forced drop to idle; deliberately no det_fall pulse.
            w_state_d  = S_IDLE;
            w_cnt_d    = '0;
            w_detect_d = 1'b0;
        end else if (r_energy_valid_q) begin
            case (r_state_q)
                S_IDLE: begin
                    if (w_hi) begin
                        if (c_confirm == c_cnt_one) begin
                            w_state_d  = S_ACTIVE;
                            w_detect_d = 1'b1;
                            w_rise_d   = 1'b1;
                            w_cnt_d    = '0;
                        end else begin
                            w_state_d  = S_ARMING;
                            w_cnt_d    = c_cnt_one;
                        end
                    end
                end
                S_ARMING: begin
                    if (w_hi) begin
                        if ((r_cnt_q + c_cnt_one) >= c_confirm) begin
                            w_state_d  = S_ACTIVE;
                            w_detect_d = 1'b1;
                            w_rise_d   = 1'b1;
                            w_cnt_d    = '0;
                        end else begin
                            w_cnt_d    = r_cnt_q + c_cnt_one;
                        end
                    end else begin
                        w_state_d = S_IDLE;
                        w_cnt_d   = '0;
                    end
                end
                S_ACTIVE: begin
                    if (w_lo) begin
                        if (c_confirm == c_cnt_one) begin
                            w_state_d  = S_IDLE;
                            w_detect_d = 1'b0;
                            w_fall_d   = 1'b1;
                            w_cnt_d    = '0;
                        end else begin
                            w_state_d  = S_RELEASING;
                            w_cnt_d    = c_cnt_one;
                        end
                    end
                end
                S_RELEASING: begin
                    if (w_lo) begin
                        if ((r_cnt_q + c_cnt_one) >= c_confirm) begin
                            w_state_d  = S_IDLE;
                            w_detect_d = 1'b0;
                            w_fall_d   = 1'b1;
                            w_cnt_d    = '0;
                        end else begin
                            w_cnt_d    = r_cnt_q + c_cnt_one;
                        end
                    end else begin
                        w_state_d = S_ACTIVE;
                        w_cnt_d   = '0;
                    end
                end
                default: begin
                    w_state_d  = S_IDLE;
                    w_cnt_d    = '0;
                    w_detect_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_q          <= '0;
            r_sat_flag_q     <= 1'b0;
            r_sat_valid_q    <= 1'b0;
            r_acc_q          <= '0;
            r_win_q          <= '0;
            r_energy_q       <= '0;
            r_energy_valid_q <= 1'b0;
            r_state_q        <= S_IDLE;
            r_cnt_q          <= '0;
            r_detect_q       <= 1'b0;
            r_rise_q         <= 1'b0;
            r_fall_q         <= 1'b0;
        end else begin
            r_sat_q          <= w_sat_d;
            r_sat_flag_q     <= w_sat_flag_d;
            r_sat_valid_q    <= in_valid;
            r_acc_q          <= w_acc_d;
            r_win_q          <= w_win_d;
            r_energy_q       <= w_energy_d;
            r_energy_valid_q <= w_energy_valid_d;
            r_state_q        <= w_state_d;
            r_cnt_q          <= w_cnt_d;
            r_detect_q       <= w_detect_d;
            r_rise_q         <= w_rise_d;
            r_fall_q         <= w_fall_d;
        end
    end

    assign sat_out      = r_sat_q;
    assign sat_valid    = r_sat_valid_q;
    assign sat_flag     = r_sat_flag_q;
    assign energy       = r_energy_q;
    assign energy_valid = r_energy_valid_q;
    assign detect       = r_detect_q;
    assign det_rise     = r_rise_q;
    assign det_fall     = r_fall_q;

endmodule
`default_nettype wire

// File: tb/tb_bpf_tone_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpf_tone_detector
// Purpose  : Self-checking bench for bpf_tone_detector (WIN_LOG2=2,
//            CONFIRM=2). Expected sample, energy and detect results are
//            queued with their due cycle when stimulus is driven, and popped
//            and compared when the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpf_tone_detector;

    localparam int IW = 39;
    localparam int OW = 16;
    localparam int WL = 2;
    localparam int CF = 2;
    localparam int EW = OW - 1 + WL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] y_in = '0;
    logic          clear = 1'b0;
    logic [EW-1:0] th_on = '1;
    logic [EW-1:0] th_off = '0;
    logic [OW-1:0] sat_out;
    logic          sat_valid;
    logic          sat_flag;
    logic [EW-1:0] energy;
    logic          energy_valid;
    logic          detect;
    logic          det_rise;
    logic          det_fall;

    bpf_tone_detector #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .WIN_LOG2 (WL),
        .CONFIRM  (CF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .y_in        (y_in),
        .clear       (clear),
        .th_on       (th_on),
        .th_off      (th_off),
        .sat_out     (sat_out),
        .sat_valid   (sat_valid),
        .sat_flag    (sat_flag),
        .energy      (energy),
        .energy_valid(energy_valid),
        .detect      (detect),
        .det_rise    (det_rise),
        .det_fall    (det_fall)
    );

    always #5 clk = ~clk;

    typedef struct { int due; longint val; logic flag; }           sat_e_t;
    typedef struct { int due; longint val; }                       en_e_t;
    typedef struct { int due; logic det; logic rise; logic fall; } det_e_t;

    sat_e_t sat_sb[$];
    en_e_t  en_sb[$];
    det_e_t det_sb[$];
    det_e_t det_plan[$];

    int     cyc      = 0;
    int     n_checks = 0;
    int     n_fail   = 0;
    longint macc     = 0;
    int     mcnt     = 0;
    logic   exp_det  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint clip(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    // Drive one cycle of input and push the matching expectations.
    task automatic send(input longint v, input logic valid);
        sat_e_t se;
        en_e_t  ee;
        det_e_t de;
        longint s;
        @(negedge clk);
        in_valid = valid;
        y_in     = IW'(v);
        clear    = 1'b0;
        if (valid) begin
            s       = clip(v);
            se.due  = cyc + 1;
            se.val  = s;
            se.flag = (s != v);
            sat_sb.push_back(se);
            macc += (s < 0) ? -s : s;
            mcnt++;
            if (mcnt == (1 << WL)) begin
                ee.due = cyc + 2;
                ee.val = macc;
                en_sb.push_back(ee);
                if (det_plan.size() > 0) de = det_plan.pop_front();
                else de = '{0, 1'b0, 1'b0, 1'b0};
                de.due = cyc + 3;
                det_sb.push_back(de);
                macc = 0;
                mcnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 1'b0);
    endtask

    task automatic window4(input longint a, input longint b, input longint c, input longint d);
        send(a, 1'b1);
        send(b, 1'b1);
        send(c, 1'b1);
        send(d, 1'b1);
    endtask

    task automatic plan(input logic d, input logic r, input logic f);
        det_e_t de;
        de = '{0, d, r, f};
        det_plan.push_back(de);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sat_out"},      longint'(sat_out), 0);
        check({tag, "_sat_valid"},    longint'(sat_valid), 0);
        check({tag, "_sat_flag"},     longint'(sat_flag), 0);
        check({tag, "_energy"},       longint'(energy), 0);
        check({tag, "_energy_valid"}, longint'(energy_valid), 0);
        check({tag, "_detect"},       longint'(detect), 0);
        check({tag, "_det_rise"},     longint'(det_rise), 0);
        check({tag, "_det_fall"},     longint'(det_fall), 0);
    endtask

    // Output monitor: compare whatever is due this cycle, otherwise require
    // the strobes to be quiet and detect to hold.
    sat_e_t m_se;
    en_e_t  m_ee;
    det_e_t m_de;
    always @(negedge clk) begin
        if (!rst) begin
            if (sat_sb.size() > 0 && sat_sb[0].due == cyc) begin
                m_se = sat_sb.pop_front();
                check("sat_valid", longint'(sat_valid), 1);
                check("sat_out",   longint'($signed(sat_out)), m_se.val);
                check("sat_flag",  longint'(sat_flag), longint'(m_se.flag));
            end else begin
                check("sat_valid_quiet", longint'(sat_valid), 0);
            end

            if (en_sb.size() > 0 && en_sb[0].due == cyc) begin
                m_ee = en_sb.pop_front();
                check("energy_valid", longint'(energy_valid), 1);
                check("energy",       longint'(energy), m_ee.val);
            end else begin
                check("energy_valid_quiet", longint'(energy_valid), 0);
            end

            if (det_sb.size() > 0 && det_sb[0].due == cyc) begin
                m_de = det_sb.pop_front();
                check("detect",   longint'(detect),   longint'(m_de.det));
                check("det_rise", longint'(det_rise), longint'(m_de.rise));
                check("det_fall", longint'(det_fall), longint'(m_de.fall));
                exp_det = m_de.det;
            end else begin
                check("detect_hold",    longint'(detect),   longint'(exp_det));
                check("det_rise_quiet", longint'(det_rise), 0);
                check("det_fall_quiet", longint'(det_fall), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        th_on  = '1;
        th_off = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Saturation (one full window, energy below th_on)
        window4(40000, -40000, -32768, 1234);
        idle(4);

        // Window energy at full rate, then a second window from zero
        window4(100, -200, 300, -400);
        window4(5, -5, 5, -5);
        idle(4);

        // Gapped input: one sample every third cycle
        send(100, 1'b1);  idle(2);
        send(-200, 1'b1); idle(2);
        send(300, 1'b1);  idle(2);
        send(-400, 1'b1); idle(4);

        // Interrupted arming
        th_on  = EW'(1000);
        th_off = EW'(500);
        plan(1'b0, 1'b0, 1'b0);
        plan(1'b0, 1'b0, 1'b0);
        window4(100, 200, 300, 400);
        window4(249, 250, 250, 250);
        idle(5);

        // Detect / release hysteresis
        plan(1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 1'b0);
        plan(1'b0, 1'b0, 1'b1);
        window4(100, 200, 300, 400);
        window4(-250, 250, -250, 250);
        window4(100, 100, 100, 100);
        window4(150, 150, 150, 150);
        window4(100, -100, 100, -100);
        window4(100, 100, 100, 100);
        idle(5);

        // Asynchronous reset two samples into a window
        send(111, 1'b1);
        send(222, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sat_sb.delete();
        en_sb.delete();
        det_sb.delete();
        macc    = 0;
        mcnt    = 0;
        exp_det = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(2);

        // Clear during ACTIVE with a sample in flight
        plan(1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b1, 1'b0);
        window4(100, 200, 300, 400);
        window4(400, 300, 200, 100);
        idle(5);
        send(50, 1'b1);
        send(60, 1'b1);
        send(70, 1'b1);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b0;
        macc     = 0;
        mcnt     = 0;
        @(posedge clk);
        exp_det = 1'b0;
        #1;
        check("clr_detect",      longint'(detect), 0);
        check("clr_det_fall",    longint'(det_fall), 0);
        check("clr_energy_hold", longint'(energy), 1000);
        @(negedge clk);
        clear = 1'b0;
        plan(1'b0, 1'b0, 1'b0);
        window4(100, 200, 300, 400);
        idle(6);

        check("scoreboard_drain",
              longint'(sat_sb.size() + en_sb.size() + det_sb.size() + det_plan.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
